// File: rtl/mac_tx_arbiter.sv
// rtl/mac_tx_arbiter.sv - packet-granular round-robin merge of ARP and IP TX streams into the 64-bit MAC TX stream; optional counters under MAC_TX_ARB_STATS_EN
module mac_tx_arbiter #(
  parameter int P_STALL_TIMEOUT = 256,
  parameter int P_USER_W        = 80
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [63:0]         s_axis_arp_data,
  input  logic [P_USER_W-1:0] s_axis_arp_user,
  input  logic [7:0]          s_axis_arp_keep,
  input  logic                s_axis_arp_last,
  input  logic                s_axis_arp_valid,
  output logic                s_axis_arp_ready,
  input  logic [63:0]         s_axis_ip_data,
  input  logic [P_USER_W-1:0] s_axis_ip_user,
  input  logic [7:0]          s_axis_ip_keep,
  input  logic                s_axis_ip_last,
  input  logic                s_axis_ip_valid,
  output logic                s_axis_ip_ready,
  output logic [63:0]         m_axis_mac_data,
  output logic [P_USER_W-1:0] m_axis_mac_user,
  output logic [7:0]          m_axis_mac_keep,
  output logic                m_axis_mac_last,
  output logic                m_axis_mac_valid,
  input  logic                m_axis_mac_ready,
  output logic                o_stall_abort
`ifdef MAC_TX_ARB_STATS_EN
  ,
  output logic [31:0]         o_arp_pkt_cnt,
  output logic [31:0]         o_ip_pkt_cnt,
  output logic [15:0]         o_abort_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_ARP = 2'd1,
    ST_GNT_IP  = 2'd2
  } state_t;

  // Counter value at which one more silent cycle means the source is declared dead
  localparam logic [15:0] LP_STALL_LAST = 16'(P_STALL_TIMEOUT - 1);

  state_t      state;
  logic        last_srv_ip;   // 1: IP was served last, so ARP wins the next tie
  logic [15:0] stall_cnt;
  logic        gnt_arp;
  logic        gnt_ip;
  logic        eop;
  logic        stall_expire;

  assign gnt_arp = (state == ST_GNT_ARP);
  assign gnt_ip  = (state == ST_GNT_IP);

  // Granted source passes straight through; IDLE drives every output low
  always_comb begin
    m_axis_mac_data  = '0;
    m_axis_mac_user  = '0;
    m_axis_mac_keep  = '0;
    m_axis_mac_last  = 1'b0;
    m_axis_mac_valid = 1'b0;
    s_axis_arp_ready = 1'b0;
    s_axis_ip_ready  = 1'b0;
    if (gnt_arp) begin
      m_axis_mac_data  = s_axis_arp_data;
      m_axis_mac_user  = s_axis_arp_user;
      m_axis_mac_keep  = s_axis_arp_keep;
      m_axis_mac_last  = s_axis_arp_last;
      m_axis_mac_valid = s_axis_arp_valid;
      s_axis_arp_ready = m_axis_mac_ready;
    end else if (gnt_ip) begin
      m_axis_mac_data  = s_axis_ip_data;
      m_axis_mac_user  = s_axis_ip_user;
      m_axis_mac_keep  = s_axis_ip_keep;
      m_axis_mac_last  = s_axis_ip_last;
      m_axis_mac_valid = s_axis_ip_valid;
      s_axis_ip_ready  = m_axis_mac_ready;
    end
  end

  // A last-beat transfer needs valid=1, so it always beats an expiry that needs valid=0
  assign eop          = m_axis_mac_valid & m_axis_mac_ready & m_axis_mac_last;
  assign stall_expire = (gnt_arp | gnt_ip) & ~m_axis_mac_valid & (stall_cnt == LP_STALL_LAST);

  // Grant FSM with stall watchdog; an aborted source counts as served for fairness
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= ST_IDLE;
      last_srv_ip   <= 1'b1;
      stall_cnt     <= '0;
      o_stall_abort <= 1'b0;
    end else begin
      o_stall_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          stall_cnt <= '0;
          if (s_axis_arp_valid && (!s_axis_ip_valid || last_srv_ip)) begin
            state <= ST_GNT_ARP;
          end else if (s_axis_ip_valid) begin
            state <= ST_GNT_IP;
          end
        end
        ST_GNT_ARP, ST_GNT_IP: begin
          if (eop) begin
            state       <= ST_IDLE;
            last_srv_ip <= gnt_ip;
            stall_cnt   <= '0;
          end else if (stall_expire) begin
            state         <= ST_IDLE;
            last_srv_ip   <= gnt_ip;
            stall_cnt     <= '0;
            o_stall_abort <= 1'b1;
          end else if (m_axis_mac_valid) begin
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          stall_cnt <= '0;
        end
      endcase
    end
  end

`ifdef MAC_TX_ARB_STATS_EN
  // Completed-packet and abort counters, wrapping at all-ones
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_arp_pkt_cnt <= '0;
      o_ip_pkt_cnt  <= '0;
      o_abort_cnt   <= '0;
    end else begin
      if (eop && gnt_arp) o_arp_pkt_cnt <= o_arp_pkt_cnt + 32'd1;
      if (eop && gnt_ip)  o_ip_pkt_cnt  <= o_ip_pkt_cnt + 32'd1;
      if (stall_expire)   o_abort_cnt   <= o_abort_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb/tb_mac_tx_arbiter.sv - randomized self-checking bench for mac_tx_arbiter with a packet-level reference model
`timescale 1ns/1ps
module tb_mac_tx_arbiter;

  localparam int T  = 8;
  localparam int UW = 80;

  typedef struct packed {
    logic [63:0]   data;
    logic [UW-1:0] user;
    logic [7:0]    keep;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 clk = ~clk;

  logic          sv [2];
  beat_t         sb [2];
  logic          m_ready;
  logic          arp_ready, ip_ready, m_valid, m_last, stall_abort;
  logic [63:0]   m_data;
  logic [UW-1:0] m_user;
  logic [7:0]    m_keep;
`ifdef MAC_TX_ARB_STATS_EN
  logic [31:0]   arp_cnt, ip_cnt;
  logic [15:0]   abort_cnt;
`endif

  mac_tx_arbiter #(.P_STALL_TIMEOUT(T), .P_USER_W(UW)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .s_axis_arp_data(sb[0].data), .s_axis_arp_user(sb[0].user), .s_axis_arp_keep(sb[0].keep),
    .s_axis_arp_last(sb[0].last), .s_axis_arp_valid(sv[0]), .s_axis_arp_ready(arp_ready),
    .s_axis_ip_data(sb[1].data), .s_axis_ip_user(sb[1].user), .s_axis_ip_keep(sb[1].keep),
    .s_axis_ip_last(sb[1].last), .s_axis_ip_valid(sv[1]), .s_axis_ip_ready(ip_ready),
    .m_axis_mac_data(m_data), .m_axis_mac_user(m_user), .m_axis_mac_keep(m_keep),
    .m_axis_mac_last(m_last), .m_axis_mac_valid(m_valid), .m_axis_mac_ready(m_ready),
    .o_stall_abort(stall_abort)
`ifdef MAC_TX_ARB_STATS_EN
    , .o_arp_pkt_cnt(arp_cnt), .o_ip_pkt_cnt(ip_cnt), .o_abort_cnt(abort_cnt)
`endif
  );

  // Source-side stimulus state
  beat_t       q_arp[$], q_ip[$];
  logic [63:0] gen_arp[$], gen_ip[$];
  int          gap [2], stall_at [2], stall_len [2], xfers [2], rate [2];
  logic        xf [2];
  bit          rnd_gaps, mr_rand;
  bit          mr_q[$];
  int          pkt_id;

  // Reference model: who owns the output, who was served last, how long the owner has been silent
  int   owner, last_srv, idle_run;
  logic exp_abort;
  int   n_pkt [2], n_ab;

  // Observation log
  int          cyc;
  int          log_cyc[$], log_src[$], log_abort[$], starts[$];
  logic [63:0] log_data[$];
  logic [7:0]  log_keep[$];
  bit          in_pkt, ip_rdy_seen;
  int          first_sv, first_arp_rdy;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add_pkt(input int s, input int n, input logic [7:0] lk);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {8'(s), 8'(pkt_id), 8'(i), 8'($urandom_range(0, 255)), 32'($urandom)};
      b.user = {16'($urandom), 32'($urandom), 32'($urandom)};
      b.keep = (i == n - 1) ? lk : 8'hff;
      b.last = (i == n - 1);
      if (s == 0) begin q_arp.push_back(b); gen_arp.push_back(b.data); end
      else        begin q_ip.push_back(b);  gen_ip.push_back(b.data);  end
    end
    pkt_id++;
  endtask

  task automatic clear_src();
    q_arp.delete(); q_ip.delete(); gen_arp.delete(); gen_ip.delete(); mr_q.delete();
    for (int s = 0; s < 2; s++) begin
      sv[s] = 1'b0; sb[s] = '0; gap[s] = 0; xf[s] = 1'b0; xfers[s] = 0;
      stall_at[s] = -1; stall_len[s] = 0; rate[s] = 100;
    end
  endtask

  task automatic model_reset();
    owner = -1; last_srv = 1; idle_run = 0; exp_abort = 1'b0; in_pkt = 0;
    n_pkt[0] = 0; n_pkt[1] = 0; n_ab = 0;
  endtask

  task automatic clear_log();
    log_cyc.delete(); log_src.delete(); log_abort.delete(); starts.delete();
    log_data.delete(); log_keep.delete();
    first_sv = -1; first_arp_rdy = -1; ip_rdy_seen = 0;
  endtask

  // A source holds its beat until accepted; otherwise it may present its next beat
  task automatic drive_src(input int s);
    int qs;
    if (xf[s]) begin
      if (s == 0) void'(q_arp.pop_front()); else void'(q_ip.pop_front());
      xfers[s]++;
      if (xfers[s] == stall_at[s]) gap[s] = stall_len[s];
      sv[s] = 1'b0;
    end
    xf[s] = 1'b0;
    if (sv[s]) return;
    qs = (s == 0) ? q_arp.size() : q_ip.size();
    sb[s] = '0;
    if (gap[s] > 0) begin gap[s]--; return; end
    if (rnd_gaps && $urandom_range(0, 99) < 4) begin gap[s] = $urandom_range(1, 12); return; end
    if (qs > 0 && $urandom_range(1, 100) <= rate[s]) begin
      sv[s] = 1'b1;
      sb[s] = (s == 0) ? q_arp[0] : q_ip[0];
    end
  endtask

  task automatic check_cycle();
    logic  exp_v, exp_ra, exp_ri;
    beat_t cur;
    exp_v  = (owner >= 0) ? sv[owner] : 1'b0;
    exp_ra = (owner == 0) ? m_ready : 1'b0;
    exp_ri = (owner == 1) ? m_ready : 1'b0;
    chk("m_valid", 128'(m_valid), 128'(exp_v));
    chk("arp_ready", 128'(arp_ready), 128'(exp_ra));
    chk("ip_ready", 128'(ip_ready), 128'(exp_ri));
    chk("stall_abort", 128'(stall_abort), 128'(exp_abort));
    if (exp_v) begin
      cur = sb[owner];
      chk("m_data", 128'(m_data), 128'(cur.data));
      chk("m_user", 128'(m_user), 128'(cur.user));
      chk("m_keep", 128'(m_keep), 128'(cur.keep));
      chk("m_last", 128'(m_last), 128'(cur.last));
    end
    xf[0] = sv[0] && arp_ready;
    xf[1] = sv[1] && ip_ready;
    if (sv[0] && first_sv < 0) first_sv = cyc;
    if (arp_ready && first_arp_rdy < 0) first_arp_rdy = cyc;
    if (ip_ready) ip_rdy_seen = 1;
    if (stall_abort) log_abort.push_back(cyc);
    if (m_valid && m_ready) begin
      log_cyc.push_back(cyc); log_src.push_back(owner);
      log_data.push_back(m_data); log_keep.push_back(m_keep);
      if (!in_pkt) starts.push_back(owner);
      in_pkt = !m_last;
    end
    // Outcome of the coming clock edge
    exp_abort = 1'b0;
    if (owner < 0) begin
      if (sv[0] && sv[1]) owner = 1 - last_srv;
      else if (sv[0])     owner = 0;
      else if (sv[1])     owner = 1;
      idle_run = 0;
    end else if (sv[owner] && m_ready && sb[owner].last) begin
      n_pkt[owner]++;
      last_srv = owner;
      owner = -1;
    end else if (sv[owner]) begin
      idle_run = 0;
    end else begin
      idle_run++;
      if (idle_run == T) begin
        exp_abort = 1'b1; n_ab++; last_srv = owner; owner = -1; idle_run = 0; in_pkt = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    drive_src(0);
    drive_src(1);
    if (mr_q.size() > 0) m_ready = mr_q.pop_front();
    else if (mr_rand)    m_ready = ($urandom_range(0, 99) < 75);
    else                 m_ready = 1'b1;
    #1;
    check_cycle();
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    clear_src();
    model_reset();
    #1;
    chk("rst m_valid", 128'(m_valid), 128'(0));
    chk("rst readies", 128'({arp_ready, ip_ready}), 128'(0));
    chk("rst abort", 128'(stall_abort), 128'(0));
    repeat (2) @(negedge clk);
    i_rst = 1'b1;
  endtask

  function automatic int nth_cyc(input int s, input int n);
    int k = 0;
    foreach (log_src[i]) if (log_src[i] == s) begin k++; if (k == n) return log_cyc[i]; end
    return -1000;
  endfunction

  function automatic int count_src(input int s);
    int k = 0;
    foreach (log_src[i]) if (log_src[i] == s) k++;
    return k;
  endfunction

  task automatic cmp_data(input string name, input int s);
    int k = 0;
    foreach (log_src[i]) if (log_src[i] == s) begin
      chk(name, 128'(log_data[i]), 128'((s == 0) ? gen_arp[k] : gen_ip[k]));
      k++;
    end
  endtask

  initial begin
    cyc = 0; pkt_id = 0; m_ready = 1'b1; rnd_gaps = 0; mr_rand = 0;
    clear_src(); model_reset(); clear_log();

    // ARP only: 6 beats, last keep 03
    do_reset(); clear_log();
    add_pkt(0, 6, 8'h03);
    repeat (12) step();
    chk("t1 latency", 128'(nth_cyc(0, 1) - first_sv), 128'(1));
    chk("t1 beats", 128'(count_src(0)), 128'(6));
    cmp_data("t1 data", 0);
    chk("t1 last keep", 128'((log_keep.size() == 6) ? log_keep[5] : 8'hxx), 128'(8'h03));
    chk("t1 ip ready", 128'(ip_rdy_seen), 128'(0));

    // Tie after reset: ARP, IP, ARP, IP with one bubble between packets
    do_reset(); clear_log();
    add_pkt(0, 3, 8'hff); add_pkt(1, 2, 8'h0f); add_pkt(0, 2, 8'h01); add_pkt(1, 2, 8'h7f);
    repeat (25) step();
    chk("t2 starts", 128'(starts.size()), 128'(4));
    foreach (starts[i]) chk("t2 start src", 128'(starts[i]), 128'(i % 2));
    chk("t2 latency", 128'(nth_cyc(0, 1) - first_sv), 128'(1));
    chk("t2 bubble", 128'(nth_cyc(1, 1) - nth_cyc(0, 3)), 128'(2));

    // Backpressure 1,0,0,1 during an IP packet, ARP waiting
    do_reset(); clear_log();
    add_pkt(1, 4, 8'h0f);
    mr_q = '{1, 1, 0, 0, 1};
    step();
    add_pkt(0, 2, 8'h01);
    repeat (20) step();
    chk("t3 ip beats", 128'(count_src(1)), 128'(4));
    cmp_data("t3 ip data", 1);
    chk("t3 arp beats", 128'(count_src(0)), 128'(2));
    chk("t3 arp held off", 128'(first_arp_rdy > nth_cyc(1, 4)), 128'(1));
    chk("t3 ip end", 128'(nth_cyc(1, 4)), 128'(nth_cyc(1, 1) + 5));

    // Stall abort: IP goes silent after beat 2; eighth silent cycle aborts, pulse follows
    do_reset(); clear_log();
    add_pkt(1, 5, 8'h3f);
    stall_at[1] = 2; stall_len[1] = 20;
    step();
    add_pkt(0, 3, 8'h07);
    repeat (40) step();
    chk("t4 abort count", 128'(log_abort.size()), 128'(1));
    chk("t4 abort time", 128'(((log_abort.size() > 0) ? log_abort[0] : -100) - nth_cyc(1, 2)), 128'(9));
    chk("t4 arp after abort", 128'(nth_cyc(0, 1) - ((log_abort.size() > 0) ? log_abort[0] : -100)), 128'(1));

    // Last-beat race: last beat arrives on the cycle the watchdog would fire
    do_reset(); clear_log();
    add_pkt(1, 3, 8'h01);
    stall_at[1] = 2; stall_len[1] = T - 1;
    repeat (20) step();
    chk("t5 no abort", 128'(log_abort.size()), 128'(0));
    chk("t5 ip beats", 128'(count_src(1)), 128'(3));
    chk("t5 last time", 128'(nth_cyc(1, 3) - nth_cyc(1, 2)), 128'(T));

    // Asynchronous reset in the middle of an ARP packet
    do_reset(); clear_log();
    add_pkt(0, 6, 8'h03);
    add_pkt(1, 2, 8'hff);
    repeat (4) step();
    chk("t6 valid before reset", 128'(m_valid), 128'(1));
    #2 i_rst = 1'b0;
    #1;
    chk("t6 async m_valid", 128'(m_valid), 128'(0));
    chk("t6 async readies", 128'({arp_ready, ip_ready}), 128'(0));
    chk("t6 async data", 128'(m_data), 128'(0));
`ifdef MAC_TX_ARB_STATS_EN
    chk("t6 stats", 128'({arp_cnt, ip_cnt, abort_cnt}), 128'(0));
`endif
    clear_src(); model_reset();
    repeat (2) @(negedge clk);
    i_rst = 1'b1;
    clear_log();
    add_pkt(1, 2, 8'hff); add_pkt(0, 2, 8'hff);
    repeat (10) step();
    chk("t6 arp first", 128'((starts.size() > 0) ? starts[0] : -1), 128'(0));

    // Randomized traffic with gaps, backpressure and occasional aborts
    do_reset(); clear_log();
    rnd_gaps = 1; mr_rand = 1;
    rate[0] = $urandom_range(40, 100); rate[1] = $urandom_range(40, 100);
    for (int n = 0; n < 3000; n++) begin
      if (q_arp.size() < 3) add_pkt(0, $urandom_range(1, 8), 8'($urandom));
      if (q_ip.size() < 3)  add_pkt(1, $urandom_range(1, 8), 8'($urandom));
      step();
    end
    rnd_gaps = 0; mr_rand = 0; rate[0] = 0; rate[1] = 0;
    repeat (60) step();
`ifdef MAC_TX_ARB_STATS_EN
    chk("stats arp", 128'(arp_cnt), 128'(n_pkt[0]));
    chk("stats ip", 128'(ip_cnt), 128'(n_pkt[1]));
    chk("stats abort", 128'(abort_cnt), 128'(n_ab));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_tx_arbiter.md
Name: mac_tx_arbiter

Overview:
- Packet-granular 2:1 arbiter directly downstream of the ARP block's transmit port (m_axis_arp_*).
- Merges the ARP TX stream and the IP/UDP TX stream into the single 64-bit AXI-Stream feeding the 10G MAC TX.
- Never interleaves beats of two packets; alternates fairly between the two sources (round-robin).
- A stall watchdog frees the output if a granted source stops mid-packet.

Parameters:
- P_STALL_TIMEOUT, 256: idle-valid cycles inside a granted packet before abort; legal range 2..65535.
- P_USER_W, 80: width of the user sideband, passed through untouched.

Ports:
- i_clk  in  1  single clock for all logic
- i_rst  in  1  asynchronous, active-low reset
- s_axis_arp_data  in  64  ARP TX data
- s_axis_arp_user  in  P_USER_W  ARP TX sideband
- s_axis_arp_keep  in  8  ARP byte enables
- s_axis_arp_last  in  1  ARP end of packet
- s_axis_arp_valid  in  1  ARP beat valid
- s_axis_arp_ready  out  1  ARP beat accept
- s_axis_ip_data  in  64  IP TX data
- s_axis_ip_user  in  P_USER_W  IP TX sideband
- s_axis_ip_keep  in  8  IP byte enables
- s_axis_ip_last  in  1  IP end of packet
- s_axis_ip_valid  in  1  IP beat valid
- s_axis_ip_ready  out  1  IP beat accept
- m_axis_mac_data  out  64  merged data to MAC
- m_axis_mac_user  out  P_USER_W  merged sideband
- m_axis_mac_keep  out  8  merged byte enables
- m_axis_mac_last  out  1  merged end of packet
- m_axis_mac_valid  out  1  merged beat valid
- m_axis_mac_ready  in  1  MAC accept
- o_stall_abort  out  1  one-cycle pulse when the watchdog aborts a packet

Behaviour:
- Reset (i_rst=0, asynchronous):
  - State goes to IDLE; r_last_srv=IP, so ARP wins the first tie.
  - Stall counter clears.
  - All m_* outputs, both s_*_ready and o_stall_abort go to 0 immediately.
- States: IDLE, GNT_ARP, GNT_IP.
- IDLE:
  - m_axis_mac_valid=0 and both readies=0.
  - Only ARP valid: next state GNT_ARP. Only IP valid: next state GNT_IP.
  - Both valid: grant the source that is not r_last_srv.
  - Arbitration latency is one cycle from valid seen in IDLE to first output beat.
- GNT_x (x = granted source):
  - m_axis_mac_{data,user,keep,last,valid} = s_axis_x_* (combinational mux).
  - s_axis_x_ready = m_axis_mac_ready; the other source's ready = 0.
  - Transfer occurs when valid && ready.
  - On a transfer with last=1: r_last_srv <= x and next state is IDLE. This gives one bubble cycle between packets.
- Beats are never reordered, dropped or modified.
  - keep is passed verbatim; no check for keep=8'h00 or a non-contiguous keep.
- Stall watchdog (GNT_x only):
  - Counter increments each cycle s_axis_x_valid=0 and resets to 0 on any cycle with valid=1.
  - When the counter reaches P_STALL_TIMEOUT-1 with valid still 0: o_stall_abort=1 for one cycle, r_last_srv <= x, state goes to IDLE.
  - The downstream packet is left truncated (no last was sent); the MAC must discard it.
  - Backpressure (valid=1, ready=0) never counts as a stall.
- A source changing data while valid=1 and ready=0 is a protocol violation and is not guarded.
- Simultaneous events:
  - If the last beat transfers in the same cycle the counter would expire, the last beat wins: no abort.
  - A new request arriving during the last beat is served only after IDLE.
- Reset mid-packet: the packet is truncated and the arbiter restarts from IDLE with ARP priority.

Optional Feature:
- Macro: MAC_TX_ARB_STATS_EN.
- When defined, adds outputs o_arp_pkt_cnt[31:0], o_ip_pkt_cnt[31:0] and o_abort_cnt[15:0].
  - Each counter increments on a completed last transfer (pkt counters) or on an abort (abort counter).
  - Counters wrap at all-ones to 0, reset to 0, and are registered.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- ARP-only: a 6-beat ARP packet (last keep=8'h03) with m_ready=1 -> the first m_valid appears 1 cycle after s_valid; the 6 beats match bit-exactly; s_axis_ip_ready stays 0.
- Tie after reset: both sources valid at cycle 0 -> ARP packet first, IP packet next (after a 1-cycle bubble); when repeated, the grant alternates IP, ARP.
- Backpressure: m_ready toggles 1,0,0,1 during an IP 4-beat packet -> no beat lost or duplicated; the ARP packet waiting meanwhile gets ready=0 throughout.
- Stall abort with P_STALL_TIMEOUT=8: the IP source drops valid after beat 2 -> o_stall_abort pulses exactly 8 cycles later; a pending ARP packet is then granted.
- Last-beat race: the last beat is presented on the cycle the counter would expire -> it transfers and no abort pulse occurs.
- Asynchronous reset asserted mid-ARP packet (between clock edges) -> m_valid=0 immediately; after release, simultaneous requests grant ARP; with MAC_TX_ARB_STATS_EN the counters read 0.
